// File: rtl/nvdla_sdp_dma_pkg.sv
// ---------------------------------------------------------------------------
// nvdla_sdp_dma_pkg
//   Shared types and widths for the SDP DMA read path. A read request is a
//   79-bit word {size, addr}: addr is a 32B-aligned byte address and size is
//   the number of 32B atoms minus one. A read response is a 257-bit word
//   {mask, data} carrying one 256-bit atom.
// ---------------------------------------------------------------------------
package nvdla_sdp_dma_pkg;

    localparam int DMA_AW     = 64;
    localparam int DMA_SZW    = 15;
    localparam int ATOM_BYTES = 32;
    localparam int RSP_DW     = 256;
    localparam int RSP_MW     = 1;

    localparam int DMA_REQ_W  = DMA_AW + DMA_SZW;
    localparam int DMA_RSP_W  = RSP_DW + RSP_MW;

    // Width of the exported credit level (enough for a limit of up to 127)
    localparam int CDT_W      = 7;

    typedef struct packed {
        logic [DMA_SZW-1:0] size;
        logic [DMA_AW-1:0]  addr;
    } dma_rd_req_t;

    typedef struct packed {
        logic [RSP_MW-1:0] mask;
        logic [RSP_DW-1:0] data;
    } dma_rd_rsp_t;

    // Fetch sequencer states: IDLE waits for a queued request, FETCH walks
    // the atoms of the current request.
    typedef enum logic {
        RSP_ST_IDLE  = 1'b0,
        RSP_ST_FETCH = 1'b1
    } rsp_fsm_e;

endpackage

// File: rtl/nvdla_sdp_rsp_req_fifo.sv
// ---------------------------------------------------------------------------
// nvdla_sdp_rsp_req_fifo
//   Flop-based synchronous FIFO that holds accepted read requests until the
//   fetch sequencer can start them. DEPTH must be a power of two.
//
// Ports
//   clk, rst_n   clock, asynchronous active-low reset
//   push         write push_data (taken when not full, or when full and
//                popping in the same cycle)
//   push_data    request word
//   pop          discard the head entry (ignored when empty)
//   pop_data     head entry (meaningless while empty)
//   full, empty  occupancy flags
// ---------------------------------------------------------------------------
module nvdla_sdp_rsp_req_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 79
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wr_ptr_q;
    logic [PW-1:0]    rd_ptr_q;
    logic [CW-1:0]    count_q;
    logic             do_push;
    logic             do_pop;

    assign full     = (count_q == CW'(DEPTH));
    assign empty    = (count_q == '0);
    assign do_pop   = pop & ~empty;
    // A pop frees the slot the push is about to use, so a full FIFO can
    // still accept in the same cycle.
    assign do_push  = push & (~full | do_pop);
    assign pop_data = mem_q[rd_ptr_q];

    // Storage needs no reset: an entry is only read after it was written.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= push_data;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two; the separate
    // count disambiguates full from empty.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= wr_ptr_q + PW'(1);
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + PW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/nvdla_sdp_mcif_rd_responder.sv
// ---------------------------------------------------------------------------
// nvdla_sdp_mcif_rd_responder
//   Memory-side stand-in for one SDP DMA read channel. Queues read requests,
//   reads their 32B atoms from a 1-cycle-latency SRAM port and returns them
//   as response beats in address order, requests in arrival order. Also
//   tracks the latency-FIFO credit (beats returned but not yet popped).
//
// Ports
//   nvdla_core_clk, nvdla_core_rstn   clock, asynchronous active-low reset
//   rd_req_valid/ready/pd             request: pd[63:0] byte addr, pd[78:64]
//                                     atoms-1
//   rd_rsp_valid/ready/pd             response beat: pd[255:0] data,
//                                     pd[256] mask (always 1)
//   rd_cdt_lat_fifo_pop               SDP releases one latency-FIFO entry
//   mem_rd_en/addr, mem_rd_data       SRAM port, data one cycle after en
//   busy                              work queued or in flight
//   cdt_err, cdt_level                only with NVDLA_SDP_RSP_CDT_CHK_EN:
//                                     sticky credit error, current credit
//
// Configuration macro: NVDLA_SDP_RSP_CDT_CHK_EN
// ---------------------------------------------------------------------------
module nvdla_sdp_mcif_rd_responder
    import nvdla_sdp_dma_pkg::*;
#(
    parameter int REQ_DEPTH = 4,
    parameter int MEM_AW    = 20,
    parameter int CDT_MAX   = 64
) (
    input  logic              nvdla_core_clk,
    input  logic              nvdla_core_rstn,
    input  logic              rd_req_valid,
    output logic              rd_req_ready,
    input  logic [78:0]       rd_req_pd,
    output logic              rd_rsp_valid,
    input  logic              rd_rsp_ready,
    output logic [256:0]      rd_rsp_pd,
    input  logic              rd_cdt_lat_fifo_pop,
    output logic              mem_rd_en,
    output logic [MEM_AW-1:0] mem_rd_addr,
    input  logic [255:0]      mem_rd_data,
    output logic              busy
`ifdef NVDLA_SDP_RSP_CDT_CHK_EN
    ,
    output logic              cdt_err,
    output logic [6:0]        cdt_level
`endif
);

    logic              fifo_push;
    logic              fifo_pop;
    logic              fifo_full;
    logic              fifo_empty;
    logic [78:0]       fifo_head_raw;
    dma_rd_req_t       fifo_head;
    logic [MEM_AW-1:0] head_atom;
    logic              unused_head_bits;

    logic              ready_en_q;
    rsp_fsm_e          state_q;
    rsp_fsm_e          state_d;
    logic [MEM_AW-1:0] addr_q;
    logic [MEM_AW-1:0] addr_d;
    logic [15:0]       remain_q;
    logic [15:0]       remain_d;
    logic              issue;
    logic [MEM_AW-1:0] issue_addr;
    logic              inflight_q;

    logic [RSP_DW-1:0] obuf_q [2];
    logic              obuf_wr_q;
    logic              obuf_rd_q;
    logic [1:0]        out_cnt_q;
    logic [2:0]        occupancy;
    logic              room;
    logic              rsp_fire;
    dma_rd_rsp_t       rsp_word;

    logic [CDT_W-1:0]  cdt_cnt_q;

    // -----------------------------------------------------------------------
    // Request queue
    // -----------------------------------------------------------------------
    assign rd_req_ready = ready_en_q & ~fifo_full;
    assign fifo_push    = rd_req_valid & rd_req_ready;

    nvdla_sdp_rsp_req_fifo #(
        .DEPTH (REQ_DEPTH),
        .WIDTH (DMA_REQ_W)
    ) u_req_fifo (
        .clk       (nvdla_core_clk),
        .rst_n     (nvdla_core_rstn),
        .push      (fifo_push),
        .push_data (rd_req_pd),
        .pop       (fifo_pop),
        .pop_data  (fifo_head_raw),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    assign fifo_head = dma_rd_req_t'(fifo_head_raw);
    assign head_atom = fifo_head.addr[MEM_AW+4:5];
    // Sub-atom offset and address bits beyond the SRAM range are don't-care.
    assign unused_head_bits = ^{fifo_head.addr[DMA_AW-1:MEM_AW+5], fifo_head.addr[4:0]};

    // -----------------------------------------------------------------------
    // Read throttle: a read issued now lands in the output buffer at the end
    // of the next cycle, so buffered beats plus the read in flight, less the
    // beat leaving this cycle, must leave a free slot. Counting the departing
    // beat is what sustains one beat per cycle with the response side open.
    // -----------------------------------------------------------------------
    assign rsp_fire  = rd_rsp_valid & rd_rsp_ready;
    assign occupancy = {1'b0, out_cnt_q} + {2'b00, inflight_q} - {2'b00, rsp_fire};
    assign room      = (occupancy < 3'd2);

    // -----------------------------------------------------------------------
    // Fetch sequencer. IDLE pops a request and issues its first atom in the
    // same cycle (from the FIFO head), which keeps accept-to-first-beat at
    // three cycles and lets back-to-back requests run without a bubble.
    // FETCH issues the remaining atoms; remain counts atoms not yet issued.
    // -----------------------------------------------------------------------
    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        remain_d   = remain_q;
        issue      = 1'b0;
        issue_addr = addr_q;
        fifo_pop   = 1'b0;
        case (state_q)
            RSP_ST_IDLE: begin
                if (!fifo_empty && room) begin
                    fifo_pop   = 1'b1;
                    issue      = 1'b1;
                    issue_addr = head_atom;
                    addr_d     = head_atom + MEM_AW'(1);
                    remain_d   = {1'b0, fifo_head.size};
                    if (fifo_head.size != '0) begin
                        state_d = RSP_ST_FETCH;
                    end
                end
            end
            RSP_ST_FETCH: begin
                if (room) begin
                    issue    = 1'b1;
                    addr_d   = addr_q + MEM_AW'(1);
                    remain_d = remain_q - 16'd1;
                    if (remain_q == 16'd1) begin
                        state_d = RSP_ST_IDLE;
                    end
                end
            end
            default: begin
                state_d = RSP_ST_IDLE;
            end
        endcase
    end

    assign mem_rd_en   = issue;
    assign mem_rd_addr = issue_addr;

    // Sequencer state, the read-in-flight marker, and the request-ready
    // enable that holds ready low until the first edge after reset release.
    always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
        if (!nvdla_core_rstn) begin
            state_q    <= RSP_ST_IDLE;
            addr_q     <= '0;
            remain_q   <= '0;
            inflight_q <= 1'b0;
            ready_en_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            remain_q   <= remain_d;
            inflight_q <= issue;
            ready_en_q <= 1'b1;
        end
    end

    // -----------------------------------------------------------------------
    // Two-entry output buffer, written from the SRAM the cycle after a read.
    // The head is only replaced after it is accepted, so the response word
    // stays stable while the consumer stalls.
    // -----------------------------------------------------------------------
    always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
        if (!nvdla_core_rstn) begin
            obuf_q[0] <= '0;
            obuf_q[1] <= '0;
            obuf_wr_q <= 1'b0;
            obuf_rd_q <= 1'b0;
            out_cnt_q <= 2'd0;
        end else begin
            if (inflight_q) begin
                obuf_q[obuf_wr_q] <= mem_rd_data;
                obuf_wr_q         <= ~obuf_wr_q;
            end
            if (rsp_fire) begin
                obuf_rd_q <= ~obuf_rd_q;
            end
            case ({inflight_q, rsp_fire})
                2'b10:   out_cnt_q <= out_cnt_q + 2'd1;
                2'b01:   out_cnt_q <= out_cnt_q - 2'd1;
                default: out_cnt_q <= out_cnt_q;
            endcase
        end
    end

    assign rd_rsp_valid  = (out_cnt_q != 2'd0);
    assign rsp_word.mask = 1'b1;
    assign rsp_word.data = obuf_q[obuf_rd_q];
    assign rd_rsp_pd     = rsp_word;

    assign busy = ~fifo_empty | (state_q == RSP_ST_FETCH) | inflight_q | (out_cnt_q != 2'd0);

    // -----------------------------------------------------------------------
    // Latency-FIFO credit. An accept and a pop in the same cycle cancel; a
    // pop with no credit outstanding is dropped and an accept at the limit
    // saturates.
    // -----------------------------------------------------------------------
    always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
        if (!nvdla_core_rstn) begin
            cdt_cnt_q <= '0;
        end else if (rsp_fire && !rd_cdt_lat_fifo_pop) begin
            if (cdt_cnt_q != CDT_W'(CDT_MAX)) begin
                cdt_cnt_q <= cdt_cnt_q + CDT_W'(1);
            end
        end else if (!rsp_fire && rd_cdt_lat_fifo_pop) begin
            if (cdt_cnt_q != '0) begin
                cdt_cnt_q <= cdt_cnt_q - CDT_W'(1);
            end
        end
    end

`ifdef NVDLA_SDP_RSP_CDT_CHK_EN
    logic cdt_err_q;

    // Sticky flag for either credit misuse; only reset clears it.
    always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
        if (!nvdla_core_rstn) begin
            cdt_err_q <= 1'b0;
        end else if (rsp_fire && !rd_cdt_lat_fifo_pop && (cdt_cnt_q == CDT_W'(CDT_MAX))) begin
            cdt_err_q <= 1'b1;
        end else if (!rsp_fire && rd_cdt_lat_fifo_pop && (cdt_cnt_q == '0)) begin
            cdt_err_q <= 1'b1;
        end
    end

    assign cdt_err   = cdt_err_q;
    assign cdt_level = cdt_cnt_q;
`else
    logic unused_cdt;
    assign unused_cdt = ^cdt_cnt_q;
`endif

endmodule
